gol_engine: RTL and testbench

Parametrised Game of Life engine with pause/run/step control, cursor editing and auto-halt. It replaces the fixed-size top-level controller/datapath pair. The grid size, edge topology and generation-counter width are parameters. It advances one generation per game-clock tick from the clock divider. It raises a halt when the pattern is stable or extinct. It emits a one-cycle update pulse so LCD and console visualisers know when to redraw.

---
 rtl/gol_engine.sv | 171 +++++++++++++++++
 tb/tb_gol_engine.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gol_engine.sv
// Game of Life engine: B3/S23 evolution over a ROWS x COLS grid with
// pause/run/step control, cursor editing, auto-halt and a redraw pulse.
module gol_engine #(
    parameter int unsigned ROWS      = 8,
    parameter int unsigned COLS      = 8,
    parameter int unsigned GEN_W     = 16,
    parameter bit          WRAP      = 1'b1,
    parameter bit          AUTO_HALT = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            tick,
    input  logic                            run_toggle,
    input  logic                            step,
    input  logic                            clear,
    input  logic                            load_en,
    input  logic [ROWS*COLS-1:0]            load_grid,
    input  logic                            btn_up,
    input  logic                            btn_down,
    input  logic                            btn_left,
    input  logic                            btn_right,
    input  logic                            btn_toggle,
    output logic [ROWS*COLS-1:0]            grid,
    output logic [$clog2(ROWS)-1:0]         cursor_row,
    output logic [$clog2(COLS)-1:0]         cursor_col,
    output logic                            running,
    output logic                            halted,
    output logic [GEN_W-1:0]                generation,
    output logic [$clog2(ROWS*COLS+1)-1:0]  population,
    output logic                            update
);
    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned PW = $clog2(ROWS * COLS + 1);

    typedef enum logic [1:0] {PAUSED, RUNNING, HALTED} state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    grid_nxt, grid_evo;
    logic [GEN_W-1:0] gen_nxt;
    logic [RW-1:0]   row_nxt;
    logic [CW-1:0]   col_nxt;
    logic            changed, chg_nxt;
    logic            edit_ok, evolve_req;

    // Next generation of every cell, computed in one combinational pass
    function automatic logic [N-1:0] evolve(input logic [N-1:0] g);
        logic [N-1:0] nxt;
        logic [N-1:0] sh;
        logic [3:0]   cnt;
        logic         alive;
        int           rr, cc;
        nxt = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                cnt = '0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (WRAP) begin
                            rr = (rr + int'(ROWS)) % int'(ROWS);
                            cc = (cc + int'(COLS)) % int'(COLS);
                        end
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < int'(ROWS)
                            && cc >= 0 && cc < int'(COLS)) begin
                            sh  = g >> (rr * int'(COLS) + cc);
                            cnt = cnt + {3'b000, sh[0]};
                        end
                    end
                end
                sh    = g >> (r * int'(COLS) + c);
                alive = (cnt == 4'd3) || (cnt == 4'd2 && sh[0]);
                nxt   = nxt | (N'(alive) << (r * int'(COLS) + c));
            end
        end
        return nxt;
    endfunction

    function automatic logic [PW-1:0] popcount(input logic [N-1:0] g);
        logic [PW-1:0] s;
        logic [N-1:0]  t;
        s = '0;
        t = g;
        for (int i = 0; i < int'(N); i++) begin
            s = s + PW'(t[0]);
            t = t >> 1;
        end
        return s;
    endfunction

    assign grid_evo = evolve(grid);

    // Next-state and datapath decisions; one grid action per cycle by priority
    always_comb begin
        state_nxt  = state;
        grid_nxt   = grid;
        gen_nxt    = generation;
        chg_nxt    = 1'b0;
        row_nxt    = cursor_row;
        col_nxt    = cursor_col;
        edit_ok    = (state != RUNNING);
        evolve_req = (state == PAUSED && step) || (state == RUNNING && tick);

        if (edit_ok && clear) begin
            grid_nxt  = '0;
            gen_nxt   = GEN_W'(1);
            chg_nxt   = 1'b1;
            state_nxt = PAUSED;
        end else if (edit_ok && load_en) begin
            grid_nxt  = load_grid;
            gen_nxt   = GEN_W'(1);
            chg_nxt   = 1'b1;
            state_nxt = PAUSED;
        end else if (run_toggle) begin
            state_nxt = (state == RUNNING) ? PAUSED : RUNNING;
        end else if (evolve_req) begin
            if (AUTO_HALT && state == RUNNING && grid_evo == grid) begin
                state_nxt = HALTED;
            end else begin
                grid_nxt = grid_evo;
                gen_nxt  = (generation == '1) ? generation : generation + GEN_W'(1);
                chg_nxt  = 1'b1;
            end
        end else if (edit_ok && btn_toggle) begin
            grid_nxt  = grid ^ (N'(1) << (int'(cursor_row) * int'(COLS) + int'(cursor_col)));
            chg_nxt   = 1'b1;
            state_nxt = PAUSED;
        end

        // Cursor moves are independent of the grid action and wrap at the edges
        if (edit_ok) begin
            if (btn_up && !btn_down)
                row_nxt = (cursor_row == '0) ? RW'(ROWS - 1) : cursor_row - RW'(1);
            else if (btn_down && !btn_up)
                row_nxt = (cursor_row == RW'(ROWS - 1)) ? '0 : cursor_row + RW'(1);
            if (btn_left && !btn_right)
                col_nxt = (cursor_col == '0) ? CW'(COLS - 1) : cursor_col - CW'(1);
            else if (btn_right && !btn_left)
                col_nxt = (cursor_col == CW'(COLS - 1)) ? '0 : cursor_col + CW'(1);
        end
    end

    // State and output registers; update/population trail the grid by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PAUSED;
            grid       <= '0;
            generation <= GEN_W'(1);
            cursor_row <= '0;
            cursor_col <= '0;
            running    <= 1'b0;
            halted     <= 1'b0;
            changed    <= 1'b0;
            update     <= 1'b0;
            population <= '0;
        end else begin
            state      <= state_nxt;
            grid       <= grid_nxt;
            generation <= gen_nxt;
            cursor_row <= row_nxt;
            cursor_col <= col_nxt;
            running    <= (state_nxt == RUNNING);
            halted     <= (state_nxt == HALTED);
            changed    <= chg_nxt;
            update     <= changed;
            population <= popcount(grid);
        end
    end
endmodule

// File: tb/tb_gol_engine.sv
// Bench for gol_engine: 5x5 torus instance tracked by a cell-array model every
// cycle, plus 4x4 wrap/no-wrap and 2-bit-generation instances with literal checks.
module tb_gol_engine;
    logic clk, rst;
    logic tick, run_toggle, step, clear;
    logic btn_up, btn_down, btn_left, btn_right, btn_toggle;
    logic load_en_a, load_en_b, load_en_c, load_en_d;
    logic [24:0] lg_a, lg_d;
    logic [15:0] lg_b;

    logic [24:0] grid_a, grid_d;
    logic [15:0] grid_b, grid_c;
    logic [2:0]  crow_a, ccol_a, crow_d, ccol_d;
    logic [1:0]  crow_b, ccol_b, crow_c, ccol_c;
    logic        run_a, run_b, run_c, run_d, halt_a, halt_b, halt_c, halt_d;
    logic        upd_a, upd_b, upd_c, upd_d;
    logic [15:0] gen_a, gen_b, gen_c;
    logic [1:0]  gen_d;
    logic [4:0]  pop_a, pop_b, pop_c, pop_d;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [24:0] HORIZ  = 25'h0003800;
    localparam logic [24:0] VERT   = 25'h0021080;
    localparam logic [24:0] BLOCK  = 25'h00018C0;
    localparam logic [24:0] GLIDER = 25'h0001C82;

    gol_engine #(.ROWS(5), .COLS(5), .GEN_W(16), .WRAP(1'b1), .AUTO_HALT(1'b1)) dut_a (
        .clk(clk), .rst(rst), .tick(tick), .run_toggle(run_toggle), .step(step),
        .clear(clear), .load_en(load_en_a), .load_grid(lg_a),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_toggle(btn_toggle), .grid(grid_a), .cursor_row(crow_a), .cursor_col(ccol_a),
        .running(run_a), .halted(halt_a), .generation(gen_a), .population(pop_a), .update(upd_a));

    gol_engine #(.ROWS(4), .COLS(4), .GEN_W(16), .WRAP(1'b1), .AUTO_HALT(1'b1)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .run_toggle(run_toggle), .step(step),
        .clear(clear), .load_en(load_en_b), .load_grid(lg_b),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_toggle(btn_toggle), .grid(grid_b), .cursor_row(crow_b), .cursor_col(ccol_b),
        .running(run_b), .halted(halt_b), .generation(gen_b), .population(pop_b), .update(upd_b));

    gol_engine #(.ROWS(4), .COLS(4), .GEN_W(16), .WRAP(1'b0), .AUTO_HALT(1'b1)) dut_c (
        .clk(clk), .rst(rst), .tick(tick), .run_toggle(run_toggle), .step(step),
        .clear(clear), .load_en(load_en_c), .load_grid(lg_b),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_toggle(btn_toggle), .grid(grid_c), .cursor_row(crow_c), .cursor_col(ccol_c),
        .running(run_c), .halted(halt_c), .generation(gen_c), .population(pop_c), .update(upd_c));

    gol_engine #(.ROWS(5), .COLS(5), .GEN_W(2), .WRAP(1'b1), .AUTO_HALT(1'b1)) dut_d (
        .clk(clk), .rst(rst), .tick(tick), .run_toggle(run_toggle), .step(step),
        .clear(clear), .load_en(load_en_d), .load_grid(lg_d),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_toggle(btn_toggle), .grid(grid_d), .cursor_row(crow_d), .cursor_col(ccol_d),
        .running(run_d), .halted(halt_d), .generation(gen_d), .population(pop_d), .update(upd_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model of instance A: 5x5 torus, states 0=paused 1=running 2=halted
    int m_g[5][5];
    int m_state, m_gen, m_cr, m_cc, m_pop;
    bit m_pend, m_upd, mon_en = 1'b0;

    function automatic int neighbours(int r, int c);
        int n = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (dr != 0 || dc != 0) n += m_g[(r + dr + 5) % 5][(c + dc + 5) % 5];
        return n;
    endfunction

    always @(posedge clk) begin
        int  nx[5][5];
        int  live, n;
        bit  same, ed, evo;
        if (rst) begin
            for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) m_g[r][c] = 0;
            m_state = 0; m_gen = 1; m_cr = 0; m_cc = 0; m_pop = 0;
            m_pend = 1'b0; m_upd = 1'b0; mon_en = 1'b1;
        end else begin
            live = 0;
            same = 1'b1;
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    live += m_g[r][c];
                    n = neighbours(r, c);
                    nx[r][c] = (n == 3 || (m_g[r][c] == 1 && n == 2)) ? 1 : 0;
                    if (nx[r][c] != m_g[r][c]) same = 1'b0;
                end
            end
            m_pop = live;
            m_upd = m_pend;
            m_pend = 1'b0;
            ed  = (m_state != 1);
            evo = (m_state == 0 && step) || (m_state == 1 && tick);
            if (ed && clear) begin
                for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) m_g[r][c] = 0;
                m_gen = 1; m_pend = 1'b1; m_state = 0;
            end else if (ed && load_en_a) begin
                for (int r = 0; r < 5; r++)
                    for (int c = 0; c < 5; c++) m_g[r][c] = int'((lg_a >> (r * 5 + c)) & 25'd1);
                m_gen = 1; m_pend = 1'b1; m_state = 0;
            end else if (run_toggle) begin
                m_state = (m_state == 1) ? 0 : 1;
            end else if (evo) begin
                if (m_state == 1 && same) m_state = 2;
                else begin
                    m_g = nx;
                    if (m_gen < 65535) m_gen++;
                    m_pend = 1'b1;
                end
            end else if (ed && btn_toggle) begin
                m_g[m_cr][m_cc] = 1 - m_g[m_cr][m_cc];
                m_pend = 1'b1; m_state = 0;
            end
            if (ed) begin
                m_cr = (m_cr + int'(btn_down) - int'(btn_up) + 5) % 5;
                m_cc = (m_cc + int'(btn_right) - int'(btn_left) + 5) % 5;
            end
        end
    end

    // Every-cycle comparison of instance A against the model
    always @(negedge clk) begin
        logic [24:0] eg;
        if (mon_en && !rst) begin
            eg = '0;
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++) eg = eg | (25'(m_g[r][c] & 1) << (r * 5 + c));
            chk("m_grid", 64'(grid_a), 64'(eg));
            chk("m_gen", 64'(gen_a), 64'(m_gen));
            chk("m_running", 64'(run_a), 64'(m_state == 1));
            chk("m_halted", 64'(halt_a), 64'(m_state == 2));
            chk("m_cursor", 64'({crow_a, ccol_a}), 64'({3'(m_cr), 3'(m_cc)}));
            chk("m_pop", 64'(pop_a), 64'(m_pop));
            chk("m_update", 64'(upd_a), 64'(m_upd));
        end
    end

    task automatic nxt();
        @(negedge clk);
        {tick, run_toggle, step, clear, btn_up, btn_down, btn_left, btn_right, btn_toggle} = '0;
        {load_en_a, load_en_b, load_en_c, load_en_d} = '0;
    endtask

    initial begin
        rst = 1'b1;
        {tick, run_toggle, step, clear, btn_up, btn_down, btn_left, btn_right, btn_toggle} = '0;
        {load_en_a, load_en_b, load_en_c, load_en_d} = '0;
        lg_a = '0; lg_b = '0; lg_d = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_grid", 64'(grid_a), 64'd0);
        chk("rst_gen", 64'(gen_a), 64'd1);
        chk("rst_cursor", 64'({crow_a, ccol_a}), 64'd0);
        chk("rst_flags", 64'({run_a, halt_a, upd_a}), 64'd0);
        chk("rst_pop", 64'(pop_a), 64'd0);
        chk("rst_gen_d", 64'(gen_d), 64'd1);

        // Edge topology: row 1 of a 4x4 grid alive, one step
        lg_b = 16'h00F0; load_en_b = 1'b1; load_en_c = 1'b1; nxt();
        step = 1'b1; nxt();
        chk("wrap_grid", 64'(grid_b), 64'h0FFF);
        chk("nowrap_grid", 64'(grid_c), 64'h0666);
        nxt();
        chk("wrap_pop", 64'(pop_b), 64'd12);
        chk("nowrap_pop", 64'(pop_c), 64'd6);

        // Blinker on the 5x5 torus
        lg_a = HORIZ; load_en_a = 1'b1; nxt();
        step = 1'b1; nxt();
        chk("blink_vert", 64'(grid_a), 64'(VERT));
        chk("blink_gen2", 64'(gen_a), 64'd2);
        nxt();
        chk("blink_upd", 64'(upd_a), 64'd1);
        chk("blink_pop", 64'(pop_a), 64'd3);
        nxt();
        chk("blink_upd_once", 64'(upd_a), 64'd0);
        step = 1'b1; nxt();
        chk("blink_horiz", 64'(grid_a), 64'(HORIZ));
        chk("blink_gen3", 64'(gen_a), 64'd3);

        // Auto-halt on a still life
        lg_a = BLOCK; load_en_a = 1'b1; nxt();
        run_toggle = 1'b1; nxt();
        chk("halt_run", 64'(run_a), 64'd1);
        tick = 1'b1; nxt();
        chk("halt_flags", 64'({run_a, halt_a}), 64'b01);
        chk("halt_gen", 64'(gen_a), 64'd1);
        chk("halt_grid", 64'(grid_a), 64'(BLOCK));
        tick = 1'b1; nxt();
        chk("halt_no_upd", 64'(upd_a), 64'd0);
        tick = 1'b1; nxt();
        clear = 1'b1; nxt();
        chk("halt_clear", 64'({run_a, halt_a}), 64'b00);
        chk("halt_clear_grid", 64'(grid_a), 64'd0);

        // Cursor wrap and cell toggle
        btn_left = 1'b1; nxt();
        btn_up = 1'b1; nxt();
        chk("cursor_wrap", 64'({crow_a, ccol_a}), 64'({3'd4, 3'd4}));
        btn_toggle = 1'b1; nxt();
        chk("toggle_cell", 64'(grid_a), 64'h1000000);
        chk("toggle_gen", 64'(gen_a), 64'd1);
        nxt();
        chk("toggle_upd", 64'(upd_a), 64'd1);
        btn_up = 1'b1; btn_down = 1'b1; btn_left = 1'b1; btn_right = 1'b1; nxt();
        chk("cursor_cancel", 64'({crow_a, ccol_a}), 64'({3'd4, 3'd4}));
        run_toggle = 1'b1; nxt();
        btn_toggle = 1'b1; btn_right = 1'b1; nxt();
        clear = 1'b1; btn_down = 1'b1; nxt();
        chk("run_no_edit", 64'(grid_a), 64'h1000000);
        chk("run_no_move", 64'({crow_a, ccol_a}), 64'({3'd4, 3'd4}));
        run_toggle = 1'b1; nxt();

        // Same-cycle priority
        lg_a = HORIZ; load_en_a = 1'b1; nxt();
        clear = 1'b1; step = 1'b1; nxt();
        chk("prio_clear_grid", 64'(grid_a), 64'd0);
        chk("prio_clear_gen", 64'(gen_a), 64'd1);
        lg_a = VERT; load_en_a = 1'b1; run_toggle = 1'b1; nxt();
        chk("prio_load_run", 64'({run_a, grid_a}), 64'({1'b0, VERT}));
        run_toggle = 1'b1; step = 1'b1; nxt();
        chk("prio_run_step", 64'({run_a, grid_a}), 64'({1'b1, VERT}));
        run_toggle = 1'b1; nxt();

        // Glider running with a tick every cycle
        lg_a = GLIDER; load_en_a = 1'b1; nxt();
        run_toggle = 1'b1; nxt();
        repeat (20) begin tick = 1'b1; nxt(); end
        run_toggle = 1'b1; nxt();

        // Mixed pulse traffic, checked by the model each cycle
        for (int i = 0; i < 300; i++) begin
            tick       = ($urandom_range(1) == 0);
            step       = ($urandom_range(3) == 0);
            run_toggle = ($urandom_range(7) == 0);
            clear      = ($urandom_range(31) == 0);
            load_en_a  = ($urandom_range(15) == 0);
            lg_a       = 25'($urandom);
            btn_up     = ($urandom_range(3) == 0);
            btn_down   = ($urandom_range(3) == 0);
            btn_left   = ($urandom_range(3) == 0);
            btn_right  = ($urandom_range(3) == 0);
            btn_toggle = ($urandom_range(3) == 0);
            nxt();
        end

        // Generation saturation with a 2-bit counter, then reset during a tick
        rst = 1'b1; nxt();
        rst = 1'b0;
        lg_d = HORIZ; load_en_d = 1'b1; nxt();
        run_toggle = 1'b1; nxt();
        tick = 1'b1; nxt();
        tick = 1'b1; nxt();
        chk("sat_gen_reach", 64'(gen_d), 64'd3);
        repeat (3) begin tick = 1'b1; nxt(); end
        chk("sat_gen", 64'(gen_d), 64'd3);
        chk("sat_grid", 64'(grid_d), 64'(VERT));
        chk("sat_running", 64'(run_d), 64'd1);
        rst = 1'b1; tick = 1'b1; nxt();
        rst = 1'b0;
        chk("rst_mid_grid", 64'(grid_d), 64'd0);
        chk("rst_mid_gen", 64'(gen_d), 64'd1);
        chk("rst_mid_state", 64'({run_d, halt_d}), 64'b00);
        nxt(); nxt();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
